// File: rtl/pll_sup_pkg.sv
`default_nettype none
// ============================================================================
// pll_sup_pkg : FSM encoding and counter sizing helper for pll_lock_supervisor
// Rev 1.0
// ============================================================================
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3
  } state_e;

  // Counter width for values 0..limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// ============================================================================
// cdc_sync_bit : multi-flop synchroniser for a single asynchronous level
// Rev 1.0
// ============================================================================
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// pll_lock_supervisor : PLL lock qualification and staged reset sequencing
// Rev 1.0
// ============================================================================
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int RELEASE_GAP        = 16,
  parameter int NUM_STAGES         = 3,
  parameter int GLITCH_FILTER      = 4,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  force_reset,
  input  logic                  clear_stats,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  ready,
  output logic [STATE_W-1:0]    state_o,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic                  lock_lost_sticky
);

  localparam int C_STAB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int C_GAP_W  = cnt_width(RELEASE_GAP);
  localparam int C_LOW_W  = cnt_width(GLITCH_FILTER);

  localparam logic [C_STAB_W-1:0]   C_STAB_LAST = C_STAB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [C_GAP_W-1:0]    C_GAP_LAST  = C_GAP_W'(RELEASE_GAP - 1);
  localparam logic [C_LOW_W-1:0]    C_LOW_LAST  = C_LOW_W'(GLITCH_FILTER - 1);
  localparam logic [LOSS_CNT_W-1:0] C_LOSS_MAX  = '1;

  state_e                  state_q, state_d;
  logic [C_STAB_W-1:0]     stab_q, stab_d;
  logic [C_GAP_W-1:0]      gap_q, gap_d;
  logic [C_LOW_W-1:0]      low_q, low_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic                    sticky_q, sticky_d;

  logic w_lock_s;
  logic w_active;
  logic w_loss;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pll_lock),
    .q_o     (w_lock_s)
  );

  assign w_active = (state_q == ST_RELEASE) || (state_q == ST_RUN);
  assign w_loss   = w_active && !w_lock_s && (low_q == C_LOW_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_WAIT;
      stab_q   <= '0;
      gap_q    <= '0;
      low_q    <= '0;
      rst_q    <= '0;
      ready_q  <= 1'b0;
      loss_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      gap_q    <= gap_d;
      low_q    <= low_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      loss_q   <= loss_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    gap_d    = gap_q;
    rst_d    = rst_q;
    ready_d  = ready_q;
    low_d    = (w_active && !w_lock_s) ? low_q + C_LOW_W'(1) : '0;
    loss_d   = clear_stats ? '0 : loss_q;
    sticky_d = clear_stats ? 1'b0 : sticky_q;

    unique case (state_q)
      ST_WAIT: begin
        if (w_lock_s) begin
          state_d = ST_STABLE;
          stab_d  = '0;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          state_d = ST_WAIT;
        end else if (stab_q == C_STAB_LAST) begin
          state_d = ST_RELEASE;
          rst_d   = NUM_STAGES'(1);
          gap_d   = '0;
        end else begin
          stab_d = stab_q + C_STAB_W'(1);
        end
      end
      ST_RELEASE: begin
        // Each gap expiry releases the next stage; the one after the last stage enters RUN.
        if (gap_q == C_GAP_LAST) begin
          gap_d = '0;
          if (&rst_q) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            rst_d = NUM_STAGES'({rst_q, 1'b1});
          end
        end else begin
          gap_d = gap_q + C_GAP_W'(1);
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_WAIT;
      end
    endcase

    if (force_reset || w_loss) begin
      state_d = ST_WAIT;
      stab_d  = '0;
      gap_d   = '0;
      low_d   = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end

    // A forced restart masks a coincident loss from the statistics.
    if (w_loss && !force_reset) begin
      sticky_d = 1'b1;
      if (loss_d != C_LOSS_MAX) begin
        loss_d = loss_d + LOSS_CNT_W'(1);
      end
    end
  end

  assign rst_n_out        = rst_q;
  assign ready            = ready_q;
  assign state_o          = state_q;
  assign loss_count       = loss_q;
  assign lock_lost_sticky = sticky_q;

endmodule
`default_nettype wire
